// File: rtl/issue_scheduler.sv
// Issue stage for the 24-bit core: scoreboards pending GPR writes, holds dependent
// instructions, and sequences branch/jump redirects toward fetch.
module issue_scheduler #(
  parameter int ALU_LAT     = 2,
  parameter int LOAD_LAT    = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [23:0]            in_instr,
  output logic                   in_ready,
  output logic                   iss_valid,
  output logic [23:0]            iss_instr,
  input  logic                   br_done_valid,
  input  logic                   br_taken,
  output logic                   flush,
  output logic [15:0]            busy_regs,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  localparam logic [3:0] OP_R  = 4'b0001;
  localparam logic [3:0] OP_I  = 4'b0010;
  localparam logic [3:0] OP_ST = 4'b0011;
  localparam logic [3:0] OP_J  = 4'b0100;
  localparam logic [3:0] OP_BR = 4'b1000;
  localparam logic [3:0] OP_LD = 4'b1100;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q [16];
  logic [CW-1:0]          cnt_d [16];
  logic                   iss_valid_q, iss_valid_d;
  logic [23:0]            iss_instr_q, iss_instr_d;
  logic                   flush_q, flush_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [3:0]    opcode, rs, rt, rd, dst;
  logic          use_rs, use_rt, dst_en;
  logic [CW-1:0] dst_lat;
  logic          hazard, issue;

  always_comb begin
    opcode  = in_instr[23:20];
    rs      = in_instr[19:16];
    rt      = in_instr[15:12];
    rd      = in_instr[11:8];
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    dst_en  = 1'b0;
    dst     = rd;
    dst_lat = CW'(ALU_LAT);
    case (opcode)
      OP_R: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dst_en = 1'b1;
      end
      OP_I: begin
        use_rs = 1'b1;
        dst_en = 1'b1;
        dst    = rt;
      end
      OP_LD: begin
        use_rs  = 1'b1;
        dst_en  = 1'b1;
        dst     = rt;
        dst_lat = CW'(LOAD_LAT);
      end
      OP_ST, OP_BR: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // RAW on either source or WAW on the destination holds the instruction.
  assign hazard = (use_rs && (cnt_q[rs] != '0)) ||
                  (use_rt && (cnt_q[rt] != '0)) ||
                  (dst_en && (cnt_q[dst] != '0));

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and fetch holds in_instr until it transfers.
  assign in_ready = (state_q == S_RUN) && !hazard;
  assign issue    = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : '0;
    end
    if (issue && dst_en) begin
      cnt_d[dst] = dst_lat;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (issue && (opcode == OP_BR)) begin
          state_d = S_BR_WAIT;
        end else if (issue && (opcode == OP_J)) begin
          state_d = S_FLUSH;
        end
      end
      S_BR_WAIT: begin
        if (br_done_valid) begin
          state_d = br_taken ? S_FLUSH : S_RUN;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    flush_d     = (state_d == S_FLUSH);
    iss_valid_d = issue;
    iss_instr_d = issue ? in_instr : iss_instr_q;
    stall_d     = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      iss_valid_q <= 1'b0;
      iss_instr_q <= '0;
      flush_q     <= 1'b0;
      stall_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      iss_valid_q <= iss_valid_d;
      iss_instr_q <= iss_instr_d;
      flush_q     <= flush_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      busy_regs[i] = (cnt_q[i] != '0);
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_instr = iss_instr_q;
  assign flush     = flush_q;
  assign stall_cnt = stall_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, all checked
// against a cycle-count based model of register availability and redirect mode.
module tb_issue_scheduler;

  localparam int ALU_LAT  = 2;
  localparam int LOAD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_instr = '0;
  logic        br_done_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        in_ready;
  logic        iss_valid;
  logic [23:0] iss_instr;
  logic        flush;
  logic [15:0] busy_regs;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  issue_scheduler #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .iss_valid(iss_valid), .iss_instr(iss_instr),
    .br_done_valid(br_done_valid), .br_taken(br_taken), .flush(flush),
    .busy_regs(busy_regs), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A register is busy while the cycle count is below the cycle its producer frees it.
  // Mode: 0 = accepting, 1 = waiting for branch outcome, 2 = redirect cycle.
  int          m_cyc;
  int          m_free_at [16];
  int          m_mode;
  logic        m_iss_valid;
  logic [23:0] m_iss_instr;
  logic        m_flush;
  logic [15:0] m_stall;

  function automatic logic m_busy(input logic [3:0] r);
    return m_free_at[r] > m_cyc;
  endfunction

  function automatic logic m_hazard(input logic [23:0] x);
    case (x[23:20])
      4'h1: return m_busy(x[19:16]) || m_busy(x[15:12]) || m_busy(x[11:8]);
      4'h2, 4'hC: return m_busy(x[19:16]) || m_busy(x[15:12]);
      4'h3, 4'h8: return m_busy(x[19:16]) || m_busy(x[15:12]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_ready(input logic [23:0] x);
    return (m_mode == 0) && !m_hazard(x);
  endfunction

  function automatic int m_lat(input logic [3:0] op);
    case (op)
      4'h1, 4'h2: return ALU_LAT;
      4'hC: return LOAD_LAT;
      default: return 0;
    endcase
  endfunction

  function automatic int m_dest(input logic [23:0] x);
    return (x[23:20] == 4'h1) ? int'(x[11:8]) : int'(x[15:12]);
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy(4'(i));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc       <= 0;
      m_mode      <= 0;
      m_iss_valid <= 1'b0;
      m_iss_instr <= '0;
      m_flush     <= 1'b0;
      m_stall     <= '0;
      for (int i = 0; i < 16; i++) m_free_at[i] <= 0;
    end else begin
      m_cyc       <= m_cyc + 1;
      m_flush     <= 1'b0;
      m_iss_valid <= in_valid && m_ready(in_instr);
      if (in_valid && !m_ready(in_instr) && (m_stall != 16'hFFFF)) m_stall <= m_stall + 16'd1;
      if (in_valid && m_ready(in_instr)) begin
        m_iss_instr <= in_instr;
        if (m_lat(in_instr[23:20]) != 0)
          m_free_at[m_dest(in_instr)] <= m_cyc + 1 + m_lat(in_instr[23:20]);
        if (in_instr[23:20] == 4'h8) m_mode <= 1;
        else if (in_instr[23:20] == 4'h4) begin
          m_mode  <= 2;
          m_flush <= 1'b1;
        end
      end else if ((m_mode == 1) && br_done_valid) begin
        if (br_taken) begin
          m_mode  <= 2;
          m_flush <= 1'b1;
        end else begin
          m_mode <= 0;
        end
      end else if (m_mode == 2) begin
        m_mode <= 0;
      end
    end
  end

  function automatic logic [58:0] dut_vec();
    return {in_ready, iss_valid, flush, busy_regs, stall_cnt, iss_instr};
  endfunction

  function automatic logic [58:0] mdl_vec();
    return {m_ready(in_instr), m_iss_valid, m_flush, m_busy_vec(), m_stall, m_iss_instr};
  endfunction

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 8'h00};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [23:0] ins, input logic bv, input logic bt);
    @(posedge clk);
    #1;
    in_valid      = v;
    in_instr      = ins;
    br_done_valid = bv;
    br_taken      = bt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    br_done_valid = 1'b0;
    br_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); end
    checks++; if (iss_instr !== 24'h0) begin errors++; $display("FAIL reset_iss_instr: got %h expected 000000", iss_instr); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (busy_regs !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0000", busy_regs); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0000", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_alu_raw();
    logic [23:0] prod = mk(4'h1, 4'd1, 4'd2, 4'd3);
    logic [23:0] cons = mk(4'h1, 4'd3, 4'd4, 4'd6);
    logic taken = 1'b0;
    logic v;
    int lows = 0, t_prod = -1, t_cons = -1;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) || !taken;
      drive(v, (i == 0) ? prod : cons, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL alu_raw_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      if (i > 0 && v && !in_ready) lows++;
      if (i > 0 && v && in_ready) taken = 1'b1;
      if (iss_valid && iss_instr === prod && t_prod < 0) t_prod = i;
      if (iss_valid && iss_instr === cons && t_cons < 0) t_cons = i;
    end
    checks++; if (lows != 2) begin errors++; $display("FAIL alu_raw_stall_cycles: got %0d expected 2", lows); end
    checks++;
    if (t_prod < 0 || t_cons - t_prod != 3) begin
      errors++; $display("FAIL alu_raw_issue_gap: got %0d expected 3", t_cons - t_prod);
    end
  endtask

  task automatic test_load_use();
    logic [23:0] ld = mk(4'hC, 4'd0, 4'd5, 4'd0);
    logic [23:0] cons = mk(4'h1, 4'd5, 4'd1, 4'd7);
    logic taken = 1'b0;
    logic v;
    int lows = 0, busy5 = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) || !taken;
      drive(v, (i == 0) ? ld : cons, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL load_use_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      if (i == 0) begin
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL load_use_stall_start: got %0d expected 0", stall_cnt); end
      end
      if (i > 0 && v && !in_ready) lows++;
      if (i > 0 && v && in_ready) taken = 1'b1;
      if (busy_regs[5]) busy5++;
    end
    checks++; if (lows != 3) begin errors++; $display("FAIL load_use_stall_cycles: got %0d expected 3", lows); end
    checks++; if (busy5 != 3) begin errors++; $display("FAIL load_use_busy5_cycles: got %0d expected 3", busy5); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_branch_taken();
    logic [23:0] br = mk(4'h8, 4'd1, 4'd2, 4'd0);
    logic [23:0] nop = '0;
    logic [5:0] exp_rdy = 6'b110001;
    logic [5:0] exp_fl  = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      drive(i != 5, (i == 0) ? br : nop, i == 2, i == 2);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL br_taken_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      checks++;
      if ({in_ready, flush} !== {exp_rdy[i], exp_fl[i]}) begin
        errors++; $display("FAIL br_taken_step%0d ready/flush: got %b%b expected %b%b", i, in_ready, flush, exp_rdy[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_branch_not_taken_jump();
    logic [23:0] br = mk(4'h8, 4'd1, 4'd2, 4'd0);
    logic [23:0] jmp = mk(4'h4, 4'd0, 4'd0, 4'd0);
    logic [23:0] nop = '0;
    logic [6:0] exp_rdy = 7'b1101101;
    logic [6:0] exp_fl  = 7'b0010000;
    logic [6:0] bv_tab  = 7'b0101010;
    for (int i = 0; i < 7; i++) begin
      drive(i != 6, (i == 0) ? br : ((i == 3) ? jmp : nop), bv_tab[i], i != 1);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL br_nt_jump_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      checks++;
      if ({in_ready, flush} !== {exp_rdy[i], exp_fl[i]}) begin
        errors++; $display("FAIL br_nt_jump_step%0d ready/flush: got %b%b expected %b%b", i, in_ready, flush, exp_rdy[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] cur, prev;
    logic [15:0] s0;
    prev = '0;
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0);
    s0 = stall_cnt;
    for (int i = 0; i < 7; i++) begin
      cur = (i % 2 == 1) ? mk(4'h2, 4'd14, 4'(1 + i), 4'd0) : mk(4'h1, 4'd14, 4'd15, 4'(1 + i));
      drive(i < 6, cur, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
      if (i < 6) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
      end
      if (i > 0) begin
        checks++;
        if ({iss_valid, iss_instr} !== {1'b1, prev}) begin
          errors++; $display("FAIL b2b_issue%0d: got %b %h expected 1 %h", i, iss_valid, iss_instr, prev);
        end
      end
      prev = cur;
    end
    checks++; if (stall_cnt !== s0) begin errors++; $display("FAIL b2b_stall_cnt: got %0d expected %0d", stall_cnt, s0); end
  endtask

  task automatic test_random();
    logic [3:0] ops [8] = '{4'h1, 4'h2, 4'hC, 4'h3, 4'h8, 4'h4, 4'h0, 4'h5};
    logic [23:0] ins;
    ins = '0;
    for (int i = 0; i < 400; i++) begin
      // Hold an instruction until it transfers, as fetch would.
      if (!(in_valid && !in_ready) || $urandom_range(0, 7) == 0)
        ins = mk(ops[$urandom_range(0, 7)], 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)));
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] ld = mk(4'hC, 4'd0, 4'd5, 4'd0);
    logic [23:0] cons = mk(4'h1, 4'd5, 4'd1, 4'd7);
    logic [23:0] br = mk(4'h8, 4'd1, 4'd2, 4'd0);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, (k == 0) ? ld : br, 1'b0, 1'b0);
      drive(1'b1, (k == 0) ? cons : 24'h0, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid%0d_pre_ready: got %b expected 0", k, in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({iss_valid, iss_instr, flush, busy_regs, stall_cnt} !== 58'h0) begin
        errors++; $display("FAIL rst_mid%0d_outputs: got %b %h %b %h %h expected all zero", k, iss_valid, iss_instr, flush, busy_regs, stall_cnt);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid%0d_ready: got %b expected 1", k, in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      // A late branch outcome after reset must not redirect.
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL rst_mid%0d_after%0d: got %h expected %h", k, i, dut_vec(), mdl_vec()); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_mid%0d_flush%0d: got %b expected 0", k, i, flush); end
      end
    end
  endtask

  task automatic test_stall_saturate();
    logic [23:0] br = mk(4'h8, 4'd1, 4'd2, 4'd0);
    do_reset();
    drive(1'b1, br, 1'b0, 1'b0);
    drive(1'b1, 24'h0, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h expected ffff", stall_cnt); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL stall_saturate_vec: got %h expected %h", dut_vec(), mdl_vec()); end
    drive(1'b0, 24'h0, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    checks++;
    if ({in_ready, flush, stall_cnt} !== {1'b1, 1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL stall_saturate_exit: got %b %b %h expected 1 0 ffff", in_ready, flush, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken_jump();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stall_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
